// File: rtl/sync_fifo_param_if.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo_param_if
// Desc    : Handshake/status bundle between a FIFO user (master) and the FIFO.
// Rev     : 1.0  initial release
// ============================================================================
interface sync_fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             wr;
  logic [WIDTH-1:0] wr_data;
  logic             rd;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, wr, wr_data, rd,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, wr, wr_data, rd,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo_param
// Desc    : Single-clock circular FIFO, any depth >= 2, registered or
//           first-word-fall-through read, occupancy and error flags.
// Rev     : 1.0  initial release
// ============================================================================
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave fifo
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PW-1:0] c_ptr_last = PW'(DEPTH - 1);
  localparam logic [CW-1:0] c_depth    = CW'(DEPTH);
  localparam logic [CW-1:0] c_af       = CW'(AF_LEVEL);
  localparam logic [CW-1:0] c_ae       = CW'(AE_LEVEL);

  generate
    if (WIDTH < 1) begin : g_chk_width
      $error("sync_fifo_param: WIDTH must be >= 1");
    end
    if (DEPTH < 2) begin : g_chk_depth
      $error("sync_fifo_param: DEPTH must be >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_chk_af
      $error("sync_fifo_param: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_chk_ae
      $error("sync_fifo_param: AE_LEVEL must be in 0..DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_chk_fwft
      $error("sync_fifo_param: FWFT must be 0 or 1");
    end
  endgenerate

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic [PW-1:0]    w_wr_ptr_nxt;
  logic [PW-1:0]    w_rd_ptr_nxt;

  assign w_full   = (r_count == c_depth);
  assign w_empty  = (r_count == '0);
  assign w_rd_acc = fifo.rd & ~w_empty;
  // A read is always accepted when full, so it frees the slot this write needs.
  assign w_wr_acc = fifo.wr & (~w_full | fifo.rd);

  assign w_wr_ptr_nxt = (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + PW'(1);

  always_ff @(posedge clk) begin
    if (!fifo.flush && w_wr_acc) begin
      r_mem[r_wr_ptr] <= fifo.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (fifo.flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (fifo.wr && !w_wr_acc) begin
        r_overflow <= 1'b1;
      end
      if (fifo.rd && !w_rd_acc) begin
        r_underflow <= 1'b1;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign fifo.rd_data  = r_mem[r_rd_ptr];
      assign fifo.rd_valid = ~w_empty;
    end else begin : g_reg
      logic [WIDTH-1:0] r_rd_data;
      logic             r_rd_valid;

      // Flush drops rd_valid but leaves the last delivered word in place.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else if (fifo.flush) begin
          r_rd_valid <= 1'b0;
        end else if (w_rd_acc) begin
          r_rd_data  <= r_mem[r_rd_ptr];
          r_rd_valid <= 1'b1;
        end else begin
          r_rd_valid <= 1'b0;
        end
      end

      assign fifo.rd_data  = r_rd_data;
      assign fifo.rd_valid = r_rd_valid;
    end
  endgenerate

  assign fifo.full         = w_full;
  assign fifo.empty        = w_empty;
  assign fifo.almost_full  = (r_count >= c_af);
  assign fifo.almost_empty = (r_count <= c_ae);
  assign fifo.count        = r_count;
  assign fifo.overflow     = r_overflow;
  assign fifo.underflow    = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_sync_fifo_param
// Desc    : Queue-model bench for sync_fifo_param: a DEPTH=5 registered FIFO
//           and a DEPTH=16 FWFT FIFO, directed cases then random traffic.
// Rev     : 1.0  initial release
// ============================================================================
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.WIDTH(8), .DEPTH(5))  ia ();
  sync_fifo_param_if #(.WIDTH(8), .DEPTH(16)) ib ();

  sync_fifo_param #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0)) dut_a (
    .clk(clk), .rst(rst), .fifo(ia.slave)
  );
  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) dut_b (
    .clk(clk), .rst(rst), .fifo(ib.slave)
  );

  int c_depth [2] = '{5, 16};
  int c_af    [2] = '{4, 14};
  int c_ae    [2] = '{1, 2};
  int c_fwft  [2] = '{0, 1};

  // Reference model: contents as a queue, flags derived from its size.
  logic [7:0] mq   [2][$];
  logic [7:0] m_rd [2] = '{8'h00, 8'h00};
  bit         m_rv [2];
  bit         m_ovf[2];
  bit         m_unf[2];

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(int k, logic f, logic w, logic r, logic [7:0] d);
    int n;
    bit racc, wacc;
    n = mq[k].size();
    if (f) begin
      mq[k].delete();
      m_ovf[k] = 1'b0;
      m_unf[k] = 1'b0;
      m_rv[k]  = 1'b0;
      return;
    end
    racc = r && (n > 0);
    wacc = w && ((n < c_depth[k]) || r);
    if (w && !wacc) m_ovf[k] = 1'b1;
    if (r && !racc) m_unf[k] = 1'b1;
    m_rv[k] = racc;
    if (racc) m_rd[k] = mq[k].pop_front();
    if (wacc) mq[k].push_back(d);
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete();
        m_rd[k]  = 8'h00;
        m_rv[k]  = 1'b0;
        m_ovf[k] = 1'b0;
        m_unf[k] = 1'b0;
      end
    end else begin
      model_step(0, ia.flush, ia.wr, ia.rd, ia.wr_data);
      model_step(1, ib.flush, ib.wr, ib.rd, ib.wr_data);
    end
  end

  task automatic cmp(int k, int cnt, logic fu, logic em, logic af, logic ae,
                     logic ov, logic un, logic rv, logic [7:0] rd);
    int n;
    string p;
    n = mq[k].size();
    p = (k == 0) ? "a" : "b";
    check({p, ".count"},        cnt, n);
    check({p, ".full"},         fu,  (n == c_depth[k]));
    check({p, ".empty"},        em,  (n == 0));
    check({p, ".almost_full"},  af,  (n >= c_af[k]));
    check({p, ".almost_empty"}, ae,  (n <= c_ae[k]));
    check({p, ".overflow"},     ov,  m_ovf[k]);
    check({p, ".underflow"},    un,  m_unf[k]);
    if (c_fwft[k] != 0) begin
      check({p, ".rd_valid"}, rv, (n > 0));
      if (n > 0) check({p, ".rd_data"}, rd, mq[k][0]);
    end else begin
      check({p, ".rd_valid"}, rv, m_rv[k]);
      check({p, ".rd_data"},  rd, m_rd[k]);
    end
  endtask

  always @(negedge clk) begin
    cmp(0, int'(ia.count), ia.full, ia.empty, ia.almost_full, ia.almost_empty,
        ia.overflow, ia.underflow, ia.rd_valid, ia.rd_data);
    cmp(1, int'(ib.count), ib.full, ib.empty, ib.almost_full, ib.almost_empty,
        ib.overflow, ib.underflow, ib.rd_valid, ib.rd_data);
  end

  task automatic drive(int k, bit f, bit w, bit r, logic [7:0] d);
    if (k == 0) begin
      ia.flush = f; ia.wr = w; ia.rd = r; ia.wr_data = d;
    end else begin
      ib.flush = f; ib.wr = w; ib.rd = r; ib.wr_data = d;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 8'h00);
    drive(1, 0, 0, 0, 8'h00);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_a(logic [7:0] base);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 0, base + 8'(i));
      tick();
    end
    drive(0, 0, 0, 0, 8'h00);
  endtask

  task automatic reset_literals(string tag);
    check({tag, ".a_count"},     ia.count, 0);
    check({tag, ".a_empty"},     ia.empty, 1);
    check({tag, ".a_full"},      ia.full, 0);
    check({tag, ".a_af"},        ia.almost_full, 0);
    check({tag, ".a_ae"},        ia.almost_empty, 1);
    check({tag, ".a_ovf"},       ia.overflow, 0);
    check({tag, ".a_unf"},       ia.underflow, 0);
    check({tag, ".a_rd_valid"},  ia.rd_valid, 0);
    check({tag, ".a_rd_data"},   ia.rd_data, 0);
    check({tag, ".b_count"},     ib.count, 0);
    check({tag, ".b_empty"},     ib.empty, 1);
    check({tag, ".b_rd_valid"},  ib.rd_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] base;
    logic [7:0] exp5 [5];
    int pw [2];
    int pr [2];

    idle();
    rst = 1'b0;
    repeat (3) tick();
    reset_literals("reset");
    #2 rst = 1'b1;
    tick();

    // Wrap and order on the DEPTH=5 registered FIFO.
    for (int rep = 0; rep < 4; rep++) begin
      base = 8'h10 + 8'(rep * 16);
      fill_a(base);
      check("wrap.full",  ia.full, 1);
      check("wrap.count", ia.count, 5);
      check("wrap.af",    ia.almost_full, 1);
      check("wrap.model_size", mq[0].size(), 5);
      for (int i = 0; i < 5; i++) begin
        drive(0, 0, 0, 1, 8'h00);
        tick();
        check("wrap.rd_valid", ia.rd_valid, 1);
        check("wrap.rd_data",  ia.rd_data, base + 8'(i));
      end
      check("wrap.empty", ia.empty, 1);
      drive(0, 0, 0, 0, 8'h00);
      tick();
      check("wrap.rd_valid_idle", ia.rd_valid, 0);
    end

    // Simultaneous read and write while full.
    fill_a(8'h50);
    drive(0, 0, 1, 1, 8'hAA);
    tick();
    check("fullrw.count",   ia.count, 5);
    check("fullrw.ovf",     ia.overflow, 0);
    check("fullrw.rd_data", ia.rd_data, 8'h50);
    exp5 = '{8'h51, 8'h52, 8'h53, 8'h54, 8'hAA};
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, 8'h00);
      tick();
      check("fullrw.seq", ia.rd_data, exp5[i]);
    end
    drive(0, 0, 0, 0, 8'h00);
    tick();

    // Overflow, underflow, persistence, flush.
    fill_a(8'h60);
    drive(0, 0, 1, 0, 8'hEE);
    tick();
    check("ovf.flag",  ia.overflow, 1);
    check("ovf.count", ia.count, 5);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, 8'h00);
      tick();
      check("ovf.seq", ia.rd_data, 8'h60 + 8'(i));
    end
    tick();
    check("unf.flag",     ia.underflow, 1);
    check("unf.rd_valid", ia.rd_valid, 0);
    drive(0, 0, 0, 0, 8'h00);
    tick();
    check("err.ovf_hold", ia.overflow, 1);
    check("err.unf_hold", ia.underflow, 1);
    drive(0, 1, 0, 0, 8'h00);
    tick();
    drive(0, 0, 0, 0, 8'h00);
    check("err.ovf_flush", ia.overflow, 0);
    check("err.unf_flush", ia.underflow, 0);
    check("err.rd_data_hold", ia.rd_data, 8'h64);

    // FWFT fall-through on the DEPTH=16 FIFO.
    drive(1, 0, 1, 0, 8'h3C);
    tick();
    drive(1, 0, 0, 0, 8'h00);
    check("fwft.rd_valid", ib.rd_valid, 1);
    check("fwft.rd_data",  ib.rd_data, 8'h3C);
    tick();
    check("fwft.hold", ib.rd_data, 8'h3C);
    drive(1, 0, 0, 1, 8'h00);
    tick();
    drive(1, 0, 0, 0, 8'h00);
    check("fwft.empty", ib.empty, 1);

    // Threshold sweep 1..16.
    for (int n = 1; n <= 16; n++) begin
      drive(1, 0, 1, 0, 8'(n));
      tick();
      check("thr.count", ib.count, n);
      check("thr.ae",    ib.almost_empty, (n <= 2));
      check("thr.af",    ib.almost_full, (n >= 14));
      check("thr.full",  ib.full, (n == 16));
    end
    drive(1, 1, 0, 0, 8'h00);
    tick();

    // Flush with a concurrent write at count 7.
    for (int n = 0; n < 7; n++) begin
      drive(1, 0, 1, 0, 8'h70 + 8'(n));
      tick();
    end
    check("flush.pre_count", ib.count, 7);
    drive(1, 1, 1, 0, 8'h77);
    tick();
    drive(1, 0, 0, 0, 8'h00);
    check("flush.count", ib.count, 0);
    check("flush.empty", ib.empty, 1);
    tick();
    check("flush.discard", ib.count, 0);

    // Asynchronous reset in the middle of a burst.
    drive(0, 0, 1, 0, 8'h21);
    drive(1, 0, 1, 1, 8'h42);
    repeat (3) tick();
    check("midrst.pre_count", ia.count, 3);
    #2 rst = 1'b0;
    #1 reset_literals("midrst");
    tick();
    #2 rst = 1'b1;
    idle();
    tick();

    // Random traffic with per-phase read/write biases.
    for (int ph = 0; ph < 8; ph++) begin
      for (int k = 0; k < 2; k++) begin
        pw[k] = 10 + $urandom_range(0, 85);
        pr[k] = 10 + $urandom_range(0, 85);
      end
      for (int c = 0; c < 500; c++) begin
        for (int k = 0; k < 2; k++) begin
          drive(k, ($urandom_range(0, 149) == 0),
                   ($urandom_range(0, 99) < pw[k]),
                   ($urandom_range(0, 99) < pr[k]),
                   8'($urandom));
        end
        tick();
      end
    end

    idle();
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
